// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state encoding and constant helpers for the LED PWM flasher
package led_pkg;

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_FLASH  = 1'b1
    } state_t;

    // All-ones mask of the given width, right-aligned; callers truncate to their bus width.
    function automatic logic [63:0] all_ones(input int unsigned width);
        all_ones = ~({64{1'b1}} << width);
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - clock prescaler and free-running PWM counter producing the duty gate
module pwm_tick_gen #(
    parameter int PRESCALE = 16,
    parameter int PWM_BITS = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                tick,
    output logic                pwm_on
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     r_prescaler;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    assign tick = (r_prescaler == PS_LAST);

    // Full-scale brightness must stay lit through the pwm_cnt == all-ones slot.
    assign pwm_on = (brightness == '1) || (r_pwm_cnt < brightness);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prescaler <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_prescaler <= tick ? '0 : r_prescaler + PS_W'(1);
            if (tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/led_pwm_flasher.sv
// rtl/led_pwm_flasher.sv - PWM-dimmed counter LED driver with full-brightness flash on counter wrap
module led_pwm_flasher
    import led_pkg::*;
#(
    parameter int N            = 6,
    parameter int PRESCALE     = 16,
    parameter int PWM_BITS     = 4,
    parameter int FLASH_CYCLES = 25000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N-1:0]        count_in,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N-1:0]        leds,
    output logic                flashing
);

    localparam int              FC_W     = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD  = FC_W'(FLASH_CYCLES - 1);
    localparam logic [N-1:0]    LED_ONES = N'(all_ones(N));

    state_t          r_state;
    state_t          w_next_state;
    logic [FC_W-1:0] r_flash_cnt;
    logic [FC_W-1:0] w_next_flash_cnt;
    logic [N-1:0]    r_count_q;
    logic [N-1:0]    r_leds;
    logic            r_flashing;
    logic            w_wrap;
    logic            w_pwm_on;
    logic            w_tick_unused;

    pwm_tick_gen #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_pwm_tick_gen (
        .clock      (clock),
        .reset_n    (reset_n),
        .brightness (brightness),
        .tick       (w_tick_unused),
        .pwm_on     (w_pwm_on)
    );

    // Only the exact all-ones -> zero step counts as a wrap.
    assign w_wrap = (r_count_q == LED_ONES) && (count_in == '0);

    always_comb begin
        w_next_state     = r_state;
        w_next_flash_cnt = r_flash_cnt;
        case (r_state)
            S_NORMAL: begin
                if (w_wrap) begin
                    w_next_state     = S_FLASH;
                    w_next_flash_cnt = FC_LOAD;
                end
            end
            S_FLASH: begin
                if (w_wrap) begin
                    w_next_flash_cnt = FC_LOAD;
                end else if (r_flash_cnt == '0) begin
                    w_next_state = S_NORMAL;
                end else begin
                    w_next_flash_cnt = r_flash_cnt - FC_W'(1);
                end
            end
            default: w_next_state = S_NORMAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_NORMAL;
            r_flash_cnt <= '0;
            r_count_q   <= '0;
            r_leds      <= '0;
            r_flashing  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_flash_cnt <= w_next_flash_cnt;
            r_count_q   <= count_in;
            r_leds      <= (w_next_state == S_FLASH) ? LED_ONES : (count_in & {N{w_pwm_on}});
            r_flashing  <= (w_next_state == S_FLASH);
        end
    end

    assign leds     = r_leds;
    assign flashing = r_flashing;

endmodule

// File: tb/tb_led_pwm_flasher.sv
// tb/tb_led_pwm_flasher.sv - directed self-checking bench for led_pwm_flasher
module tb_led_pwm_flasher;

    localparam int N            = 6;
    localparam int PRESCALE     = 4;
    localparam int PWM_BITS     = 4;
    localparam int FLASH_CYCLES = 10;

    logic                clock;
    logic                reset_n;
    logic [N-1:0]        count_in;
    logic [PWM_BITS-1:0] brightness;
    logic [N-1:0]        leds;
    logic                flashing;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int ons;

    led_pwm_flasher #(
        .N            (N),
        .PRESCALE     (PRESCALE),
        .PWM_BITS     (PWM_BITS),
        .FLASH_CYCLES (FLASH_CYCLES)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .count_in   (count_in),
        .brightness (brightness),
        .leds       (leds),
        .flashing   (flashing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running edge count since reset release: the PWM phase reference.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Expected LED value for a non-flash cycle sampled after the latest edge.
    function automatic logic [N-1:0] ref_leds(input logic [N-1:0] cnt, input logic [PWM_BITS-1:0] b, input int c);
        int  slot;
        logic on;
        slot = ((c - 1) / PRESCALE) % (1 << PWM_BITS);
        on   = (b == 4'hF) || (slot < int'(b));
        return on ? cnt : 6'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset_n    = 1'b0;
        count_in   = '0;
        brightness = '0;
        repeat (2) @(negedge clock);
        check("reset_leds", 32'(leds), 32'h00);
        check("reset_flashing", 32'(flashing), 32'h0);
        reset_n = 1'b1;

        // Full on
        brightness = 4'hF;
        count_in   = 6'h2A;
        for (int i = 0; i < 8; i++) begin
            step();
            check("fullon_leds", 32'(leds), 32'h2A);
            check("fullon_flashing", 32'(flashing), 32'h0);
        end

        // Duty 4/16 over one 64-cycle period
        brightness = 4'd4;
        count_in   = 6'h3F;
        ons = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            check("duty4_leds", 32'(leds), 32'(ref_leds(6'h3F, 4'd4, cyc)));
            if (leds == 6'h3F) ons++;
        end
        check("duty4_on_count", 32'(ons), 32'd16);

        // Brightness 0 keeps LEDs dark (3F held, so no wrap)
        brightness = 4'd0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("duty0_leds", 32'(leds), 32'h00);
        end

        // Wrap flash: 3F -> 00 gives exactly FLASH_CYCLES of flash
        brightness = 4'hF;
        step();
        check("prewrap_leds", 32'(leds), 32'h3F);
        count_in = 6'h00;
        for (int i = 0; i < FLASH_CYCLES; i++) begin
            step();
            check("flash_flashing", 32'(flashing), 32'h1);
            check("flash_leds", 32'(leds), 32'h3F);
        end
        step();
        check("flash_end_flashing", 32'(flashing), 32'h0);
        check("flash_end_leds", 32'(leds), 32'h00);

        // 3F -> 01 is not a wrap
        count_in = 6'h3F;
        step();
        count_in = 6'h01;
        for (int i = 0; i < 3; i++) begin
            step();
            check("nowrap_flashing", 32'(flashing), 32'h0);
            check("nowrap_leds", 32'(leds), 32'h01);
        end

        // 00 -> 00 is not a wrap
        count_in = 6'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("zero_hold_flashing", 32'(flashing), 32'h0);
        end

        // Retrigger: second wrap 5 cycles into the flash
        count_in = 6'h3F;
        step();
        count_in = 6'h00;
        for (int i = 0; i < 15; i++) begin
            if (i == 4) count_in = 6'h3F;
            if (i == 5) count_in = 6'h00;
            step();
            check("retrig_flashing", 32'(flashing), 32'h1);
            check("retrig_leds", 32'(leds), 32'h3F);
        end
        step();
        check("retrig_end_flashing", 32'(flashing), 32'h0);

        // Async reset in the middle of a flash
        count_in = 6'h3F;
        step();
        count_in = 6'h00;
        step();
        step();
        check("pre_reset_flashing", 32'(flashing), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_leds", 32'(leds), 32'h00);
        check("async_reset_flashing", 32'(flashing), 32'h0);
        @(negedge clock);
        reset_n  = 1'b1;
        count_in = 6'h2A;
        step();
        check("post_reset_leds", 32'(leds), 32'h2A);
        check("post_reset_flashing", 32'(flashing), 32'h0);

        // PWM continuity across a flash
        brightness = 4'd8;
        count_in   = 6'h3F;
        for (int i = 0; i < 22; i++) begin
            step();
            check("cont_pre_leds", 32'(leds), 32'(ref_leds(6'h3F, 4'd8, cyc)));
        end
        count_in = 6'h00;
        step();
        check("cont_wrap_flashing", 32'(flashing), 32'h1);
        count_in = 6'h3F;
        for (int i = 0; i < FLASH_CYCLES - 1; i++) begin
            step();
            check("cont_flash_leds", 32'(leds), 32'h3F);
        end
        for (int i = 0; i < 70; i++) begin
            step();
            check("cont_post_flashing", 32'(flashing), 32'h0);
            check("cont_post_leds", 32'(leds), 32'(ref_leds(6'h3F, 4'd8, cyc)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
